id_ex_pipeline: RTL
===================

Name: id_ex_pipeline

Overview:
- ID/EX pipeline register of the 5-stage core. Sits directly downstream of the opcode control decoder and register file.
- Captures decoded control bits, operands, immediate and register fields each cycle, and performs immediate extension.
- Detects load-use hazards and inserts bubbles.
- Applies branch/jump flushes and external freezes.
- Counts inserted bubbles for performance monitoring.

Parameters:
- DATA_W, 32, operand/immediate/PC width.
- RADDR_W, 5, register-specifier width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_sign_zero  in  1 each  decoder control bits.
- id_alu_op  in  2  decoder ALU op.
- id_pc4  in  DATA_W  PC+4 of ID instruction.
- id_rdata1, id_rdata2  in  DATA_W  register-file read data.
- id_imm  in  16  raw immediate.
- id_rs, id_rt, id_rd  in  RADDR_W  instruction register fields.
- flush  in  1  branch/jump resolved taken; kill the ID instruction.
- hold  in  1  external pipeline freeze.
- ex_reg_write, ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1 each  registered control bits.
- ex_alu_op  out  2  registered ALU op.
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  out  DATA_W  registered data; ex_imm is extended.
- ex_rs, ex_rt, ex_dst  out  RADDR_W  registered fields; ex_dst is the resolved destination.
- hazard_stall  out  1  combinational; tells the PC and IF/ID registers to hold.
- bubble_count  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (async, asserted): all outputs zero, bubble_count = 0. Reset mid-operation discards in-flight state immediately. The first edge after deassertion behaves normally.
- Latency: one cycle. Inputs sampled at edge N appear on ex_* after edge N.
- Immediate extension:
  - id_sign_zero = 0: ex_imm = {{16{id_imm[15]}}, id_imm} (sign extend).
  - id_sign_zero = 1: ex_imm = {16'b0, id_imm} (zero extend).
  - For DATA_W > 32, extend with the same fill to full width.
- Destination: ex_dst = id_reg_dst ? id_rd : id_rt, resolved at capture.
- Load-use detection (combinational):
  - load_use = ex_mem_read & (ex_dst != 0) & ((ex_dst == id_rs) | (ex_dst == id_rt)).
  - hazard_stall = load_use & ~flush & ~hold.
- Per-edge action, priority order:
  1. flush = 1: load a bubble; data/field registers capture normally.
  2. hold = 1 (no flush): all registers keep their value; bubble_count unchanged.
  3. load_use = 1: load a bubble.
  4. Otherwise: capture all inputs.
- Bubble: ex_reg_write, ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_jump = 0 and ex_alu_op = 2'b00.
- Because a bubble clears ex_mem_read, a load-use stall lasts exactly one cycle.
- bubble_count increments by 1 on every edge that loads a bubble (flush or load_use) and saturates at all-ones.
- Simultaneous flush + hold: flush wins; the bubble is loaded.
- Simultaneous flush + load_use: one bubble, counted once; hazard_stall stays low.
- Register 0 is never a hazard source.
- Illegal/unknown control inputs are passed through unmodified; the decoder owns their validity.

Test Plan:
- Reset: assert reset mid-stream with ex_reg_write = 1 → all outputs 0 within the same cycle, bubble_count = 0. Release reset → the next edge captures inputs.
- Passthrough: R-type with reg_dst = 1, rs = 3, rt = 4, rd = 5, rdata1 = 0x11, rdata2 = 0x22, alu_op = 10 → after one edge: ex_dst = 5, ex_reg_write = 1, ex_alu_op = 10, data matches.
- Extension: imm = 0x8001 with sign_zero = 0 → ex_imm = 0xFFFF8001; with sign_zero = 1 → ex_imm = 0x00008001.
- Load-use:
  - lw with rt = 7, reg_dst = 0, followed by ID rs = 7 → hazard_stall = 1 for exactly one cycle, bubble loaded, bubble_count = 1.
  - Same sequence with rt = 0 → no stall.
- Flush/hold priority:
  - hold = 1 for 3 cycles → ex_* frozen, count unchanged.
  - flush = 1 together with hold = 1 → bubble loaded, count +1.
  - flush during load_use → single bubble, hazard_stall = 0.
- Saturation: preload via 2^CNT_W − 1 flushes, then one more flush → bubble_count stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register: captures decoded control, operands and register fields,
// extends the immediate, detects load-use hazards, applies flush/hold and counts bubbles.
`timescale 1ns/1ps
module id_ex_pipeline #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_reg_dst,
    input  logic               id_alu_src,
    input  logic               id_mem_to_reg,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_branch,
    input  logic               id_jump,
    input  logic               id_sign_zero,
    input  logic [1:0]         id_alu_op,
    input  logic [DATA_W-1:0]  id_pc4,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [15:0]        id_imm,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               flush,
    input  logic               hold,
    output logic               ex_reg_write,
    output logic               ex_alu_src,
    output logic               ex_mem_to_reg,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [1:0]         ex_alu_op,
    output logic [DATA_W-1:0]  ex_pc4,
    output logic [DATA_W-1:0]  ex_rdata1,
    output logic [DATA_W-1:0]  ex_rdata2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_dst,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_count
);

    // Control vector layout: {reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, jump, alu_op[1:0]}
    localparam int CTRL_W        = 9;
    localparam int CTRL_MEM_READ = 5;

    function automatic logic [DATA_W-1:0] extend_imm(input logic [15:0] imm, input logic zero_ext);
        logic fill;
        if (zero_ext) begin
            fill = 1'b0;
        end else begin
            fill = imm[15];
        end
        extend_imm = {{(DATA_W-16){fill}}, imm};
    endfunction

    logic [CTRL_W-1:0]  id_ctrl_s;
    logic [CTRL_W-1:0]  ctrl_next_s;
    logic [RADDR_W-1:0] dst_next_s;
    logic [DATA_W-1:0]  imm_next_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               load_use_s;
    logic               hazard_stall_s;
    logic               bubble_s;
    logic               capture_s;

    logic [CTRL_W-1:0]  ctrl_r;
    logic [DATA_W-1:0]  pc4_r;
    logic [DATA_W-1:0]  rdata1_r;
    logic [DATA_W-1:0]  rdata2_r;
    logic [DATA_W-1:0]  imm_r;
    logic [RADDR_W-1:0] rs_r;
    logic [RADDR_W-1:0] rt_r;
    logic [RADDR_W-1:0] dst_r;
    logic [CNT_W-1:0]   cnt_r;

    assign id_ctrl_s = {id_reg_write, id_alu_src, id_mem_to_reg, id_mem_read,
                        id_mem_write, id_branch, id_jump, id_alu_op};

    // Hazard detection, per-edge action selection and next-state values
    always_comb begin
        load_use_s     = 1'b0;
        hazard_stall_s = 1'b0;
        bubble_s       = 1'b0;
        capture_s      = 1'b0;
        ctrl_next_s    = id_ctrl_s;
        dst_next_s     = id_rt;
        imm_next_s     = extend_imm(id_imm, id_sign_zero);
        cnt_next_s     = cnt_r;

        load_use_s = ctrl_r[CTRL_MEM_READ] & (dst_r != {RADDR_W{1'b0}}) &
                     ((dst_r == id_rs) | (dst_r == id_rt));
        hazard_stall_s = load_use_s & ~flush & ~hold;
        // A flush overrides hold and hides any load-use so only one bubble is counted
        bubble_s  = flush | (~hold & load_use_s);
        capture_s = flush | ~hold;

        if (bubble_s) begin
            ctrl_next_s = {CTRL_W{1'b0}};
        end else begin
            ctrl_next_s = id_ctrl_s;
        end

        if (id_reg_dst) begin
            dst_next_s = id_rd;
        end else begin
            dst_next_s = id_rt;
        end

        if (bubble_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Pipeline register and bubble counter; hold freezes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_r   <= {CTRL_W{1'b0}};
            pc4_r    <= {DATA_W{1'b0}};
            rdata1_r <= {DATA_W{1'b0}};
            rdata2_r <= {DATA_W{1'b0}};
            imm_r    <= {DATA_W{1'b0}};
            rs_r     <= {RADDR_W{1'b0}};
            rt_r     <= {RADDR_W{1'b0}};
            dst_r    <= {RADDR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (capture_s) begin
            ctrl_r   <= ctrl_next_s;
            pc4_r    <= id_pc4;
            rdata1_r <= id_rdata1;
            rdata2_r <= id_rdata2;
            imm_r    <= imm_next_s;
            rs_r     <= id_rs;
            rt_r     <= id_rt;
            dst_r    <= dst_next_s;
            cnt_r    <= cnt_next_s;
        end
    end

    assign ex_reg_write  = ctrl_r[8];
    assign ex_alu_src    = ctrl_r[7];
    assign ex_mem_to_reg = ctrl_r[6];
    assign ex_mem_read   = ctrl_r[5];
    assign ex_mem_write  = ctrl_r[4];
    assign ex_branch     = ctrl_r[3];
    assign ex_jump       = ctrl_r[2];
    assign ex_alu_op     = ctrl_r[1:0];
    assign ex_pc4        = pc4_r;
    assign ex_rdata1     = rdata1_r;
    assign ex_rdata2     = rdata2_r;
    assign ex_imm        = imm_r;
    assign ex_rs         = rs_r;
    assign ex_rt         = rt_r;
    assign ex_dst        = dst_r;
    assign hazard_stall  = hazard_stall_s;
    assign bubble_count  = cnt_r;

endmodule
